// File: rtl/async_queue_pkg.sv
// Shared types and Gray-code helpers for both halves of the async queue.
package async_queue_pkg;

   localparam int DEF_WIDTH = 10;
   localparam int DEF_DEPTH = 8;
   localparam int DEF_SYNC  = 3;

   function automatic logic [31:0] bin2gray(input logic [31:0] b);
      return b ^ (b >> 1);
   endfunction

   function automatic logic [31:0] gray2bin(input logic [31:0] g);
      logic [31:0] b;
      b[31] = g[31];
      for (int i = 30; i >= 0; i--)
         b[i] = b[i+1] ^ g[i];
      return b;
   endfunction

endpackage

// File: rtl/async_queue_sink_if.sv
// Sink-side bundle: producer storage/pointers in, dequeue stream out.
// The reset handshake flags exist only with ASYNC_QUEUE_SINK_SAFE_EN.
interface async_queue_sink_if
   import async_queue_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH
);

   localparam int AW = $clog2(DEPTH);

   logic [DEPTH*WIDTH-1:0] async_mem;
   logic [AW:0]            async_widx;
   logic [AW:0]            async_ridx;
   logic                   deq_valid;
   logic                   deq_ready;
   logic [WIDTH-1:0]       deq_bits;
`ifdef ASYNC_QUEUE_SINK_SAFE_EN
   logic                   async_widx_valid;
   logic                   async_ridx_valid;
`endif

   modport master (
      input  async_mem,
      input  async_widx,
      output async_ridx,
      output deq_valid,
      input  deq_ready,
      output deq_bits
`ifdef ASYNC_QUEUE_SINK_SAFE_EN
      ,
      input  async_widx_valid,
      output async_ridx_valid
`endif
   );

   modport slave (
      output async_mem,
      output async_widx,
      input  async_ridx,
      input  deq_valid,
      output deq_ready,
      input  deq_bits
`ifdef ASYNC_QUEUE_SINK_SAFE_EN
      ,
      output async_widx_valid,
      input  async_ridx_valid
`endif
   );

endinterface

// File: rtl/async_sync_chain.sv
// Multi-flop synchronizer, synchronous active-low reset to zero.
module async_sync_chain #(
   parameter int W      = 1,
   parameter int STAGES = 3
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [STAGES-1:0][W-1:0] stg;

   always_ff @(posedge clock) begin
      if (!reset_n)
         stg <= '0;
      else
         stg <= {stg[STAGES-2:0], d};
   end

   assign q = stg[STAGES-1];

endmodule

// File: rtl/async_queue_sink.sv
// Consumer-domain half of the CDC queue: sync write pointer, one-entry output reg.
// Optional reset handshake with ASYNC_QUEUE_SINK_SAFE_EN.
module async_queue_sink
   import async_queue_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH,
   parameter int DEPTH = DEF_DEPTH,
   parameter int SYNC  = DEF_SYNC
) (
   input  logic               clock,
   input  logic               reset_n,
   async_queue_sink_if.master io
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;

   typedef logic [PW-1:0] ptr_t;

   ptr_t             widx_s;
   ptr_t             ridx_bin;
   ptr_t             ridx_gray;
   ptr_t             ridx_bin_nx;
   ptr_t             ridx_gray_nx;
   logic [AW-1:0]    head;
   logic [WIDTH-1:0] head_data;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             alive;
   logic             empty;
   logic             load;

   async_sync_chain #(
      .W      (PW),
      .STAGES (SYNC)
   ) u_widx_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (io.async_widx),
      .q       (widx_s)
   );

`ifdef ASYNC_QUEUE_SINK_SAFE_EN
   logic ridx_valid_q;

   async_sync_chain #(
      .W      (1),
      .STAGES (SYNC)
   ) u_valid_sync (
      .clock   (clock),
      .reset_n (reset_n),
      .d       (io.async_widx_valid),
      .q       (alive)
   );

   always_ff @(posedge clock) begin
      if (!reset_n)
         ridx_valid_q <= 1'b0;
      else
         ridx_valid_q <= 1'b1;
   end

   assign io.async_ridx_valid = ridx_valid_q;
`else
   assign alive = 1'b1;
`endif

   assign head         = ridx_bin[AW-1:0];
   assign head_data    = io.async_mem[int'(head)*WIDTH +: WIDTH];
   assign ridx_bin_nx  = ridx_bin + ptr_t'(1);
   assign ridx_gray_nx = ptr_t'(bin2gray(32'(ridx_bin_nx)));

   assign empty = !alive || (ridx_gray == widx_s);
   assign load  = !empty && (!valid_q || io.deq_ready);

   // Pointer moves on capture, so the producer regains the slot a cycle early.
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         ridx_bin  <= '0;
         ridx_gray <= '0;
         valid_q   <= 1'b0;
         data_q    <= '0;
      end else if (!alive) begin
         ridx_bin  <= '0;
         ridx_gray <= '0;
         valid_q   <= 1'b0;
      end else if (load) begin
         data_q    <= head_data;
         valid_q   <= 1'b1;
         ridx_bin  <= ridx_bin_nx;
         ridx_gray <= ridx_gray_nx;
      end else if (io.deq_ready) begin
         valid_q   <= 1'b0;
      end
   end

   assign io.deq_valid  = valid_q;
   assign io.deq_bits   = data_q;
   assign io.async_ridx = ridx_gray;

endmodule

// File: doc/async_queue_sink.md
# async_queue_sink

Receive-side half of the clock-domain-crossing queue used between the debug module and its neighbouring domains. It sits in the consumer's clock domain, takes the producer's shared storage array and Gray-coded write pointer, and presents entries as a valid/ready dequeue stream. It returns its own Gray-coded read pointer to the producer for full detection. The block is the counterpart of the existing async queue source, which carries the 10-bit debug control payload.

## Interface
Parameters:
- WIDTH, 10, payload bits per entry
- DEPTH, 8, queue entries; power of two, at least 2
- SYNC, 3, synchronizer stages on incoming pointers; at least 2

Ports:
- clock  in  1  sink-domain clock; the only clock
- reset_n  in  1  synchronous reset, active-low
- async_mem  in  DEPTH*WIDTH  producer storage; entry i occupies bits [i*WIDTH +: WIDTH]
- async_widx  in  AW+1  producer write pointer, Gray code; AW = $clog2(DEPTH)
- async_ridx  out  AW+1  read pointer, Gray code, driven directly from a flop
- deq_valid  out  1  dequeue entry available
- deq_ready  in  1  consumer accepts the entry
- deq_bits  out  WIDTH  dequeue payload, driven from a flop
- async_widx_valid  in  1  producer-alive flag; present only with ASYNC_QUEUE_SINK_SAFE_EN
- async_ridx_valid  out  1  sink-alive flag; present only with ASYNC_QUEUE_SINK_SAFE_EN

## Operation
- async_widx passes through a SYNC-stage synchronizer that resets to 0. The result is widx_s.
- The read pointer is held as ridx_bin (AW+1 bits, binary) and as ridx_gray (a registered copy of bin2gray(ridx_bin)). Both are updated in the same cycle.
- The head index is ridx_bin[AW-1:0].
- empty = (ridx_gray == widx_s). Full detection belongs to the source and is not computed here.
- The output stage is one register: valid_q and data_q.
  - load = !empty && (!valid_q || deq_ready).
  - On load: data_q <= async_mem entry [head]; valid_q <= 1; ridx_bin <= ridx_bin + 1, wrapping modulo 2*DEPTH.
  - Otherwise, if deq_ready: valid_q <= 0.
- deq_valid = valid_q. deq_bits = data_q. async_ridx = ridx_gray.
- A transfer occurs when deq_valid && deq_ready in the same cycle.
- Once deq_valid is asserted it stays asserted, with deq_bits stable, until that transfer occurs.
- A simultaneous transfer and load in the same cycle gives back-to-back entries with no bubble.
- The read pointer advances when an entry enters the output register, not when the consumer takes it. The slot therefore frees one cycle early, which is safe because the data has already been captured.
- Reset (reset_n low at a clock edge) sets ridx_bin, ridx_gray, valid_q, data_q and all synchronizer stages to 0, including mid-transfer. Any entry held in the output register is discarded.

## Timing
- Reset values: deq_valid 0, deq_bits 0, async_ridx 0, async_ridx_valid 0.
- Latency from an async_widx change to deq_valid high is SYNC+1 sink-clock cycles when the output register is empty.
- Sustained throughput is one entry per cycle while the queue is non-empty and deq_ready is held high.
- async_ridx changes at most once per cycle and changes by exactly one Gray step.
- Wrap-around: ridx_bin goes 2*DEPTH-1 -> 0. The Gray code wraps cleanly with a single bit change.

## Configuration
- ASYNC_QUEUE_SINK_SAFE_EN, when defined, adds the reset handshake:
  - async_widx_valid passes through its own SYNC-stage synchronizer, which resets to 0.
  - While the synchronized flag is 0: empty is forced true, ridx_bin and ridx_gray are held at 0, and valid_q is cleared.
  - async_ridx_valid is a flop that is 0 in reset and 1 from the first cycle after reset_n goes high.
  - Effect: a source reset flushes the sink, and the sink announces its own liveness to the source.
- When the macro is undefined, both ports are absent, the flag is treated as constant 1, and no handshake logic is built.

## Structure
- Package async_queue_pkg:
  - functions bin2gray and gray2bin
  - default constants: WIDTH 10, DEPTH 8, SYNC 3
  - shared with the source half
- Sub-module async_sync_chain:
  - parameterized width and stage count
  - synchronous active-low reset to 0
  - used for widx and for the valid flag

## Test plan
- Reset with async_widx=0 -> deq_valid=0, async_ridx=0 throughout. Release reset, drive async_widx=Gray(1) with entry 0 = 10'h2A5 -> deq_valid rises exactly 4 cycles later (SYNC=3), deq_bits=10'h2A5, async_ridx=Gray(1).
- Fill 8 entries (values 0..7) with async_widx=Gray(8) and deq_ready held at 1 -> eight consecutive beats 0..7 with no bubble; async_ridx steps Gray(1)..Gray(8); deq_valid then drops.
- Hold deq_ready=0 with 3 entries available -> only entry 0 is loaded, async_ridx=Gray(1), deq_bits is stable. Raise deq_ready -> entries 1 and 2 follow on consecutive cycles.
- Run 20 entries through, wrapping past index 15 -> async_ridx goes Gray(15) -> Gray(0) with a single bit change, and the data order is preserved.
- Assert reset_n low while deq_valid=1 -> deq_valid=0, deq_bits=0 and async_ridx=0 on the next edge.
- With ASYNC_QUEUE_SINK_SAFE_EN: drop async_widx_valid while 2 entries are pending -> after SYNC cycles, deq_valid=0 and async_ridx=0. async_ridx_valid stays at 1.
